// File: rtl/latch_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : latch_write_sequencer_if
// Brief   : Producer handshake, latch drive/readback and status bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface latch_write_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic             done;
    logic             err;
    logic             err_seen;

    // master: producer plus latch readback side; slave: the sequencer
    modport master (
        output valid, data, q,
        input  ready, en, a, done, err, err_seen
    );

    modport slave (
        input  valid, data, q,
        output ready, en, a, done, err, err_seen
    );
endinterface
`default_nettype wire

// File: rtl/latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : latch_write_sequencer
// Brief   : Sequences setup/open/hold windows into a level-sensitive latch.
// Revision: 1.0 - initial release
// ============================================================================
module latch_write_sequencer #(
    parameter int WIDTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 1,
    parameter int HOLD_CYC  = 1
) (
    input wire logic              clk,
    input wire logic              rst,
    latch_write_sequencer_if.slave bus
);
    localparam int c_max_a   = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int c_max_cyc = (c_max_a > HOLD_CYC) ? c_max_a : HOLD_CYC;
    localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

    localparam logic [c_cnt_w-1:0] c_setup_ld = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_open_ld  = c_cnt_w'(OPEN_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_hold_ld  = c_cnt_w'(HOLD_CYC - 1);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_setup = 3'd1;
    localparam logic [2:0] c_open  = 3'd2;
    localparam logic [2:0] c_hold  = 3'd3;
    localparam logic [2:0] c_check = 3'd4;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_en;
    logic [WIDTH-1:0]   r_a;
    logic               r_done;
    logic               r_err;
    logic               r_err_seen;

    logic w_ready;
    logic w_accept;
    logic w_cnt_zero;
    logic w_mismatch;

    assign w_ready    = (r_state == c_idle) && !rst;
    assign w_accept   = bus.valid && w_ready;
    assign w_cnt_zero = (r_cnt == '0);
    // The latch has been closed since OPEN ended, so q is stable by the edge into CHECK
    assign w_mismatch = (bus.q != r_a);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_cnt      <= '0;
            r_en       <= 1'b0;
            r_a        <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_seen <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_a     <= bus.data;
                        r_cnt   <= c_setup_ld;
                        r_state <= c_setup;
                    end
                end
                c_setup: begin
                    if (w_cnt_zero) begin
                        r_en    <= 1'b1;
                        r_cnt   <= c_open_ld;
                        r_state <= c_open;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_open: begin
                    if (w_cnt_zero) begin
                        r_en    <= 1'b0;
                        r_cnt   <= c_hold_ld;
                        r_state <= c_hold;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_hold: begin
                    if (w_cnt_zero) begin
                        r_done     <= 1'b1;
                        r_err      <= w_mismatch;
                        r_err_seen <= r_err_seen | w_mismatch;
                        r_state    <= c_check;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_check: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_en    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.ready    = w_ready;
    assign bus.en       = r_en;
    assign bus.a        = r_a;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.err_seen = r_err_seen;
endmodule
`default_nettype wire

// File: tb/tb_latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_latch_write_sequencer
// Brief   : Directed bench for default and stretched-window sequencers.
// Revision: 1.0 - initial release
// ============================================================================
module tb_latch_write_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    latch_write_sequencer_if #(.WIDTH(4)) bus1 ();
    latch_write_sequencer_if #(.WIDTH(4)) bus2 ();

    latch_write_sequencer #(.WIDTH(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    latch_write_sequencer #(.WIDTH(4), .SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    // Behavioural downstream latches; dut1's can have bits forced low
    logic [3:0] lat1 = 4'h0;
    logic [3:0] lat2 = 4'h0;
    logic [3:0] stuck_mask = 4'h0;
    always @* if (bus1.en) lat1 = bus1.a;
    always @* if (bus2.en) lat2 = bus2.a;
    assign bus1.q = lat1 & ~stuck_mask;
    assign bus2.q = lat2;

    logic       sel = 1'b0;
    logic       m_ready, m_en, m_done, m_err, m_seen;
    logic [3:0] m_a;
    assign m_ready = sel ? bus2.ready    : bus1.ready;
    assign m_en    = sel ? bus2.en       : bus1.en;
    assign m_done  = sel ? bus2.done     : bus1.done;
    assign m_err   = sel ? bus2.err      : bus1.err;
    assign m_seen  = sel ? bus2.err_seen : bus1.err_seen;
    assign m_a     = sel ? bus2.a        : bus1.a;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full write; k counts negedge samples after the accepting edge
    task automatic do_write(input logic s, input logic [3:0] d, input int sc, input int oc,
                            input int hc, input logic exp_err, input logic exp_seen,
                            input string tag);
        int b;
        int t;
        sel = s;
        @(negedge clk);
        bus1.data = d;
        bus2.data = d;
        if (s) bus2.valid = 1'b1; else bus1.valid = 1'b1;
        b = 0;
        while (!m_ready && b < 20) begin
            @(negedge clk);
            b++;
        end
        chk({tag, " accept_ready"}, 32'(m_ready), 32'd1);
        @(negedge clk);
        bus1.valid = 1'b0;
        bus2.valid = 1'b0;
        t = sc + oc + hc;
        for (int k = 0; k <= t + 1; k++) begin
            chk($sformatf("%s en k%0d", tag, k), 32'(m_en), 32'(k >= sc && k < sc + oc));
            chk($sformatf("%s a k%0d", tag, k), 32'(m_a), 32'(d));
            chk($sformatf("%s done k%0d", tag, k), 32'(m_done), 32'(k == t));
            chk($sformatf("%s err k%0d", tag, k), 32'(m_err), 32'((k == t) && exp_err));
            chk($sformatf("%s ready k%0d", tag, k), 32'(m_ready), 32'(k == t + 1));
            if (k == t) chk({tag, " err_seen"}, 32'(m_seen), 32'(exp_seen));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0] exp_a;
        rst = 1'b1;
        bus1.valid = 1'b0;
        bus2.valid = 1'b0;
        bus1.data  = 4'h0;
        bus2.data  = 4'h0;
        @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(bus1.ready), 32'd0);
        chk("reset en", 32'(bus1.en), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle ready %0d", i), 32'(bus1.ready), 32'd1);
            chk($sformatf("idle en %0d", i), 32'(bus1.en), 32'd0);
            chk($sformatf("idle a %0d", i), 32'(bus1.a), 32'd0);
            chk($sformatf("idle done %0d", i), 32'(bus1.done), 32'd0);
            chk($sformatf("idle seen %0d", i), 32'(bus1.err_seen), 32'd0);
        end

        do_write(1'b0, 4'hA, 1, 1, 1, 1'b0, 1'b0, "wrA");

        // Back-to-back with valid held: 3 accepted at E0, C at E5
        sel = 1'b0;
        @(negedge clk);
        chk("b2b idle_ready", 32'(bus1.ready), 32'd1);
        bus1.data  = 4'h3;
        bus1.valid = 1'b1;
        @(negedge clk);
        bus1.data = 4'hC;
        for (int k = 0; k <= 10; k++) begin
            exp_a = (k < 5) ? 4'h3 : 4'hC;
            if (k == 5) bus1.valid = 1'b0;
            chk($sformatf("b2b a k%0d", k), 32'(bus1.a), 32'(exp_a));
            chk($sformatf("b2b en k%0d", k), 32'(bus1.en), 32'(k == 1 || k == 6));
            chk($sformatf("b2b done k%0d", k), 32'(bus1.done), 32'(k == 3 || k == 8));
            chk($sformatf("b2b ready k%0d", k), 32'(bus1.ready), 32'(k == 4 || k == 9 || k == 10));
            @(negedge clk);
        end

        stuck_mask = 4'h1;
        do_write(1'b0, 4'h1, 1, 1, 1, 1'b1, 1'b1, "wr_stuck");
        stuck_mask = 4'h0;
        do_write(1'b0, 4'h2, 1, 1, 1, 1'b0, 1'b1, "wr_after_err");

        do_write(1'b1, 4'h5, 2, 3, 2, 1'b0, 1'b0, "wr_long");

        // Reset while dut1 is in OPEN
        sel = 1'b0;
        @(negedge clk);
        bus1.data  = 4'h7;
        bus1.valid = 1'b1;
        @(negedge clk);
        bus1.valid = 1'b0;
        @(negedge clk);
        chk("rst_mid en_before", 32'(bus1.en), 32'd1);
        chk("rst_mid seen_before", 32'(bus1.err_seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid en", 32'(bus1.en), 32'd0);
        chk("rst_mid a", 32'(bus1.a), 32'd0);
        chk("rst_mid seen", 32'(bus1.err_seen), 32'd0);
        chk("rst_mid done", 32'(bus1.done), 32'd0);
        chk("rst_mid ready", 32'(bus1.ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst done %0d", i), 32'(bus1.done), 32'd0);
            chk($sformatf("post_rst ready %0d", i), 32'(bus1.ready), 32'd1);
        end
        do_write(1'b0, 4'h9, 1, 1, 1, 1'b0, 1'b0, "wr9");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
